// File: rtl/bin_to_oct_dec.sv
// bin_to_oct_dec: FIFO of 3-bit codes presenting each head code as a one-hot byte.
// Optional macro BIN_TO_OCT_DEC_CNT_EN adds a saturating count of delivered words on dec_cnt.
module bin_to_oct_dec #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_bin,
    input  logic                     en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_d,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              dec_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [2:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          r_live;
    logic          w_push;
    logic          w_pop;
    logic [2:0]    w_head;

    // in_ready stays low until the first edge after reset release; level is registered so a same-cycle pop never re-opens a full FIFO
    assign in_ready  = r_live && (r_level != LW'(DEPTH));
    assign out_valid = (r_level != '0) && en;
    assign w_head    = r_mem[r_rptr];
    assign out_d     = out_valid ? (8'd1 << w_head) : 8'h00;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign level     = r_level;

    // code storage needs no reset: level alone decides which entries are meaningful
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= in_bin;
    end

    // pointers wrap naturally since DEPTH is a power of two; level tracks push minus pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_live  <= 1'b0;
        end else begin
            r_live  <= 1'b1;
            r_wptr  <= w_push ? r_wptr + AW'(1) : r_wptr;
            r_rptr  <= w_pop ? r_rptr + AW'(1) : r_rptr;
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

`ifdef BIN_TO_OCT_DEC_CNT_EN
    logic [15:0] r_cnt;

    // delivered-word counter, sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else if (w_pop && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end

    assign dec_cnt = r_cnt;
`else
    assign dec_cnt = 16'h0000;
`endif
endmodule

// File: doc/bin_to_oct_dec.md
BIN_TO_OCT_DEC -- requirements
Module: bin_to_oct_dec

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, a 3-bit code is offered.
REQ-005 The block SHALL have port in_ready, output, 1, the block can accept a code this cycle.
REQ-006 The block SHALL have port in_bin, input, 3, the binary code 0..7.
REQ-007 The block SHALL have port en, input, 1, output-enable; low stalls the output side only.
REQ-008 The block SHALL have port out_valid, output, 1, out_d holds a decoded word.
REQ-009 The block SHALL have port out_ready, input, 1, the downstream consumer takes the word.
REQ-010 The block SHALL have port out_d, output, 8, one-hot decode of the head code (bit k set for code k).
REQ-011 The block SHALL have port level, output, $clog2(DEPTH)+1, the number of stored codes.
REQ-012 The block SHALL have port dec_cnt, output, 16, the count of decoded words delivered.

Function
REQ-013 Push: in_valid && in_ready SHALL write in_bin at the tail; in_ready SHALL equal (level != DEPTH).
REQ-014 Pop: out_valid && out_ready SHALL remove the head; out_valid SHALL equal (level != 0) && en.
REQ-015 out_d SHALL be (8'b1 << head code) when out_valid is 1 and 8'h00 otherwise; never more than one bit set.
REQ-016 Latency: a code pushed in cycle N SHALL be presented with out_valid no earlier than cycle N+1; there is no combinational in->out bypass.
REQ-017 Codes SHALL leave in push order; out_d SHALL hold stable while out_valid && !out_ready.
REQ-018 Simultaneous push and pop SHALL leave level unchanged, and both operations SHALL complete.
REQ-019 When full (level == DEPTH), in_ready SHALL be 0; a same-cycle pop SHALL NOT re-enable in_ready within that cycle.
REQ-020 When empty, out_valid SHALL be 0 and out_d SHALL be 8'h00; out_ready SHALL be ignored.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH with no loss or duplication.
REQ-022 With en = 0, pops SHALL be blocked while pushes continue normally; when en returns to 1, the held head SHALL appear the same cycle.
REQ-023 level SHALL be registered, range 0..DEPTH.

Reset
REQ-024 With rst_n = 0, the block SHALL asynchronously clear the pointers, level, and dec_cnt, and SHALL force in_ready = 0, out_valid = 0, and out_d = 8'h00.
REQ-025 in_ready SHALL rise in the first clk edge after rst_n deasserts; reset mid-transfer SHALL discard all stored codes.

Configuration
REQ-026 With macro BIN_TO_OCT_DEC_CNT_EN defined, dec_cnt SHALL increment by 1 on each pop and saturate at 16'hFFFF.
REQ-027 Without BIN_TO_OCT_DEC_CNT_EN, dec_cnt SHALL be constant 16'h0000 and no counter logic SHALL be built.

Verification
REQ-028 Reset, then push codes 0..7 with out_ready = 1: the bench SHALL see out_d = 01,02,04,08,10,20,40,80 in order, each one cycle after its push.
REQ-029 DEPTH = 4 with out_ready = 0, push 5,1,7,3, then offer 6: level SHALL be 4, in_ready SHALL be 0, and 6 SHALL NOT be accepted; then pop all, and the bench SHALL see 20,02,80,08.
REQ-030 At level 2, push and pop in the same cycle: level SHALL stay 2 and order SHALL be preserved; a 100-cycle random push/pop run SHALL see no loss across wrap-around.
REQ-031 With en = 0, push 4 codes: the bench SHALL see out_valid = 0, out_d = 00, and level = 4; raise en, and the bench SHALL see out_valid = 1 with the first code that cycle.
REQ-032 Deassert rst_n with 3 codes stored: out_valid SHALL be 0 and level SHALL be 0 immediately, and no codes SHALL appear afterwards.
REQ-033 With BIN_TO_OCT_DEC_CNT_EN defined, after 70000 pops dec_cnt SHALL read FFFF; without the macro, dec_cnt SHALL read 0000 throughout.
